// File: rtl/eth_tx_framer_if.sv
// ---------------------------------------------------------------------------
// eth_tx_framer_if -- byte stream interface feeding the Ethernet TX framer.
//
// Signals:
//   s_data  [7:0]  payload byte, destination MAC first
//   s_valid        s_data / s_last are valid
//   s_last         current byte is the last payload byte of the frame
//   s_ready        framer takes the byte this cycle
//
// Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
// are both high. s_ready is a single-cycle request raised by the framer only
// when it needs the next byte (bit 7 of the SFD or of a non-last data byte).
// The source must already hold s_valid high in that cycle; s_valid low while
// s_ready is high aborts the frame (underrun). s_data/s_last must stay stable
// while s_valid is high and the byte has not yet been taken.
//
// Modports: master = byte source, slave = framer.
// ---------------------------------------------------------------------------
interface eth_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer -- 10 Mb/s Ethernet transmit framer, one NRZ bit per clk.
//
// Wraps a payload byte stream into preamble + SFD + payload (+ zero pad) +
// CRC-32 FCS, serialised LSB first, followed by the interframe gap.
//
// Parameters:
//   IPG_BITS        interframe gap in bit times (>= 1), default 96
//   PREAMBLE_BYTES  number of 0x55 bytes before the SFD (>= 1), default 7
//
// Ports:
//   clk, rst        bit clock, synchronous active-high reset
//   s               byte stream (eth_tx_framer_if.slave)
//   tx_bit          serial NRZ bit, forced 0 while tx_en is low
//   tx_en           frame on the wire
//   busy            frame start through end of the IPG
//   frame_done      one-cycle pulse on the last FCS bit
//   underrun        one-cycle pulse when the frame is aborted for lack of data
//   dbg_state_o     current FSM state encoding
//
// Build option: define ETH_TX_PAD_EN to zero-pad payloads shorter than 60
// bytes up to 60 before the FCS. Without it there is no PAD state.
// ---------------------------------------------------------------------------
module eth_tx_framer #(
    parameter int IPG_BITS       = 96,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic                clk,
    input  logic                rst,
    eth_tx_framer_if.slave      s,
    output logic                tx_bit,
    output logic                tx_en,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun,
    output logic [2:0]          dbg_state_o
);

    localparam int          IPG_W    = (IPG_BITS > 1) ? $clog2(IPG_BITS) : 1;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
`ifdef ETH_TX_PAD_EN
        ST_PAD      = 3'd4,
`endif
        ST_FCS      = 3'd5,
        ST_IPG      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [10:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               last_q, last_d;
    logic [31:0]        crc_q, crc_d;
    logic [IPG_W-1:0]   ipg_cnt_q, ipg_cnt_d;
    logic [10:0]        byte_inc;
    logic               byte_end;

    // Reflected CRC-32, one bit per call.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    endfunction

    assign byte_inc    = (byte_cnt_q == 11'd2047) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign byte_end    = (bit_cnt_q == 3'd7);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        crc_d      = crc_q;
        ipg_cnt_d  = ipg_cnt_q;
        s.s_ready  = 1'b0;
        tx_en      = 1'b0;
        tx_bit     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        underrun   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (s.s_valid) begin
                    state_d    = ST_PREAMBLE;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 11'd0;
                    crc_d      = 32'hFFFF_FFFF;
                end
            end

            ST_PREAMBLE: begin
                tx_en     = 1'b1;
                tx_bit    = ~bit_cnt_q[0];   // 0x55 LSB first: 1,0,1,0...
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    if (byte_cnt_q == 11'(PREAMBLE_BYTES - 1)) begin
                        state_d    = ST_SFD;
                        byte_cnt_d = 11'd0;
                    end else begin
                        byte_cnt_d = byte_inc;
                    end
                end
            end

            ST_SFD: begin
                tx_en     = 1'b1;
                tx_bit    = SFD_BYTE[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    s.s_ready = 1'b1;
                    if (s.s_valid) begin
                        state_d = ST_DATA;
                        shift_d = s.s_data;
                        last_d  = s.s_last;
                    end else begin
                        underrun  = 1'b1;
                        state_d   = ST_IPG;
                        ipg_cnt_d = '0;
                    end
                end
            end

            ST_DATA: begin
                tx_en     = 1'b1;
                tx_bit    = shift_q[0];
                crc_d     = crc_step(crc_q, shift_q[0]);
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    byte_cnt_d = byte_inc;
                    if (!last_q) begin
                        s.s_ready = 1'b1;
                        if (s.s_valid) begin
                            shift_d = s.s_data;
                            last_d  = s.s_last;
                        end else begin
                            underrun  = 1'b1;
                            state_d   = ST_IPG;
                            ipg_cnt_d = '0;
                        end
                    end else begin
`ifdef ETH_TX_PAD_EN
                        if (byte_inc < 11'd60) begin
                            state_d = ST_PAD;
                            shift_d = 8'h00;
                        end else begin
                            state_d    = ST_FCS;
                            byte_cnt_d = 11'd0;
                        end
`else
                        state_d    = ST_FCS;
                        byte_cnt_d = 11'd0;
`endif
                    end
                end
            end

`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                tx_en     = 1'b1;
                crc_d     = crc_step(crc_q, 1'b0);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    if (byte_inc >= 11'd60) begin
                        state_d    = ST_FCS;
                        byte_cnt_d = 11'd0;
                    end else begin
                        byte_cnt_d = byte_inc;
                    end
                end
            end
`endif

            ST_FCS: begin
                // byte_cnt counts the four FCS bytes; the CRC register is
                // shifted out and inverted on the way.
                tx_en     = 1'b1;
                tx_bit    = ~crc_q[0];
                crc_d     = crc_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    if (byte_cnt_q == 11'd3) begin
                        frame_done = 1'b1;
                        state_d    = ST_IPG;
                        ipg_cnt_d  = '0;
                    end else begin
                        byte_cnt_d = byte_inc;
                    end
                end
            end

            ST_IPG: begin
                ipg_cnt_d = ipg_cnt_q + IPG_W'(1);
                if (ipg_cnt_q == IPG_W'(IPG_BITS - 1)) begin
                    // A waiting frame starts straight out of the last gap
                    // cycle so back-to-back frames see exactly IPG_BITS idle.
                    if (s.s_valid) begin
                        state_d    = ST_PREAMBLE;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 11'd0;
                        crc_d      = 32'hFFFF_FFFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 11'd0;
            shift_q    <= 8'h00;
            last_q     <= 1'b0;
            crc_q      <= 32'hFFFF_FFFF;
            ipg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            crc_q      <= crc_d;
            ipg_cnt_q  <= ipg_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_framer -- self-checking bench for eth_tx_framer (default
// parameters). Expected wire bit streams come from a byte-level frame model
// (preamble/SFD/payload/pad/FCS assembled as bytes, CRC computed bytewise).
// Honours ETH_TX_PAD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_eth_tx_framer;

    localparam int IPG = 96;
    localparam int PRE = 7;

    typedef logic [7:0] bq_t[$];
    typedef logic       lq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_bit, tx_en, busy, frame_done, underrun;
    logic [2:0] dbg_state;

    eth_tx_framer_if bus ();

    eth_tx_framer #(.IPG_BITS(IPG), .PREAMBLE_BYTES(PRE)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus.slave),
        .tx_bit     (tx_bit),
        .tx_en      (tx_en),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- monitor (sampled on negedge) ----------------
    logic cap_q[$];        // every tx_bit seen while tx_en high
    int   flen_q[$];       // length of each tx_en high run
    int   gap_q[$];        // tx_en low runs between frames
    int   tail_q[$];       // busy-high / tx_en-low runs (the IPG)
    int   fd_cnt = 0, ur_cnt = 0, rdy_cnt = 0;
    int   zbad = 0, urbad = 0;
    int   run_len = 0, low_run = 0, post = 0;
    logic en_prev = 1'b0, ur_prev = 1'b0, seen = 1'b0;

    always @(negedge clk) begin
        if (tx_en) cap_q.push_back(tx_bit);
        if (!tx_en && tx_bit) zbad++;
        if (ur_prev && tx_en) urbad++;
        ur_prev = underrun;
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        if (bus.s_ready && bus.s_valid) rdy_cnt++;
        if (tx_en) begin
            if (!en_prev && seen && low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
            seen    = 1'b1;
            run_len++;
        end else begin
            if (en_prev) flen_q.push_back(run_len);
            run_len = 0;
            low_run++;
        end
        if (busy && !tx_en) post++;
        else if (post > 0) begin
            tail_q.push_back(post);
            post = 0;
        end
        en_prev = tx_en;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] fcs_of(bq_t p);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (p[i]) begin
            c = c ^ {24'd0, p[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic lq_t bytes_to_bits(bq_t w);
        lq_t  b;
        logic [7:0] v;
        foreach (w[i]) begin
            v = w[i];
            for (int k = 0; k < 8; k++) b.push_back(v[k]);
        end
        return b;
    endfunction

    function automatic bq_t wire_bytes(bq_t p);
        bq_t w;
        bq_t body;
        logic [31:0] f;
        body = p;
`ifdef ETH_TX_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        f = fcs_of(body);
        for (int i = 0; i < PRE; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (body[i]) w.push_back(body[i]);
        for (int i = 0; i < 4; i++) w.push_back(f[8*i +: 8]);
        return w;
    endfunction

    // Number of differing bits between capture (from index start) and exp,
    // counting any length difference as errors.
    function automatic int stream_errs(int start, lq_t exp);
        int e = 0;
        int n = cap_q.size() - start;
        if (n != exp.size()) e = (n > exp.size()) ? n - exp.size() : exp.size() - n;
        for (int i = 0; i < n && i < exp.size(); i++)
            if (cap_q[start + i] !== exp[i]) e++;
        return e;
    endfunction

    function automatic bq_t rand_payload(int len);
        bq_t p;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    function automatic lq_t last_flags(int len);
        lq_t l;
        for (int i = 0; i < len; i++) l.push_back(i == len - 1);
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents bytes in order; drop_at withholds s_valid for that byte index,
    // stop_at returns once that many bytes have been taken.
    task automatic drive(input bq_t d, input lq_t l, input int drop_at, input int stop_at);
        int   idx   = 0;
        int   guard = 0;
        logic take;
        bus.s_data  = d[0];
        bus.s_last  = l[0];
        bus.s_valid = 1'b1;
        while (idx < d.size() && idx != stop_at) begin
            @(negedge clk);
            if (bus.s_ready && !bus.s_valid) break;
            take = bus.s_ready && bus.s_valid;
            guard++;
            if (guard > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: %0d of %0d bytes taken, required all", idx, d.size());
                break;
            end
            @(posedge clk);
            #1;
            if (take) begin
                idx++;
                if (idx < d.size()) begin
                    bus.s_data  = d[idx];
                    bus.s_last  = l[idx];
                    bus.s_valid = (idx != drop_at);
                end else begin
                    bus.s_valid = 1'b0;
                end
            end
        end
        if (idx != stop_at) bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, guard);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom_range(0, 255));
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (tx_en !== 1'b0)      begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        if (tx_bit !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_bit: got %b want 0", tx_bit); end
        if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        if (underrun !== 1'b0)   begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b tx_en=%b want 0/0", busy, tx_en);
        end
    endtask

    task automatic test_check_value();
        bq_t p;
        bq_t w;
        lq_t exp;
        int  c0 = cap_q.size(), f0 = flen_q.size(), fd0 = fd_cnt, r0 = rdy_cnt;
        int  e, want_len;
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
`ifdef ETH_TX_PAD_EN
        w        = wire_bytes(p);
        want_len = 576;
`else
        for (int i = 0; i < PRE; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (p[i]) w.push_back(p[i]);
        w.push_back(8'h26); w.push_back(8'h39); w.push_back(8'hF4); w.push_back(8'hCB);
        want_len = 168;
`endif
        exp = bytes_to_bits(w);
        drive(p, last_flags(9), -1, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks += 4;
        if (e !== 0) begin n_fail++; $display("FAIL check_stream: %0d bit errors, want 0", e); end
        if (flen_q.size() <= f0 || flen_q[flen_q.size()-1] !== want_len) begin
            n_fail++; $display("FAIL check_tx_en_len: got %0d want %0d", (flen_q.size() > f0) ? flen_q[flen_q.size()-1] : -1, want_len);
        end
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL check_frame_done: got %0d want 1", fd_cnt - fd0); end
        if (rdy_cnt - r0 !== 9) begin n_fail++; $display("FAIL check_ready: got %0d want 9", rdy_cnt - r0); end
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 4; t++) begin
            int  len = $urandom_range(1, 70);
            bq_t p   = rand_payload(len);
            lq_t exp = bytes_to_bits(wire_bytes(p));
            int  c0 = cap_q.size(), fd0 = fd_cnt, r0 = rdy_cnt, e;
            drive(p, last_flags(len), -1, -1);
            wait_idle();
            e = stream_errs(c0, exp);
            n_checks += 4;
            if (e !== 0) begin n_fail++; $display("FAIL rand_stream[%0d] len=%0d: %0d bit errors, want 0", t, len, e); end
            if (flen_q[flen_q.size()-1] !== exp.size()) begin
                n_fail++; $display("FAIL rand_tx_en_len[%0d]: got %0d want %0d", t, flen_q[flen_q.size()-1], exp.size());
            end
            if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL rand_frame_done[%0d]: got %0d want 1", t, fd_cnt - fd0); end
            if (rdy_cnt - r0 !== len) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0d want %0d", t, rdy_cnt - r0, len); end
        end
    endtask

    task automatic test_sixty_bytes();
        bq_t p;
        lq_t exp;
        int  c0 = cap_q.size(), r0 = rdy_cnt, e;
        for (int i = 0; i < 60; i++) p.push_back(8'(i));
        exp = bytes_to_bits(wire_bytes(p));
        drive(p, last_flags(60), -1, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks += 4;
        if (e !== 0) begin n_fail++; $display("FAIL sixty_stream: %0d bit errors, want 0", e); end
        if (flen_q[flen_q.size()-1] !== 576) begin n_fail++; $display("FAIL sixty_tx_en_len: got %0d want 576", flen_q[flen_q.size()-1]); end
        if (rdy_cnt - r0 !== 60) begin n_fail++; $display("FAIL sixty_ready: got %0d want 60", rdy_cnt - r0); end
        if (tail_q[tail_q.size()-1] !== IPG) begin n_fail++; $display("FAIL sixty_ipg: got %0d want %0d", tail_q[tail_q.size()-1], IPG); end
    endtask

    task automatic test_short_payload();
        bq_t p   = rand_payload(14);
        lq_t exp = bytes_to_bits(wire_bytes(p));
        int  c0 = cap_q.size(), e, want;
`ifdef ETH_TX_PAD_EN
        want = 576;
`else
        want = 8 * PRE + 8 + 8 * 14 + 32;
`endif
        drive(p, last_flags(14), -1, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks += 2;
        if (e !== 0) begin n_fail++; $display("FAIL short_stream: %0d bit errors, want 0", e); end
        if (flen_q[flen_q.size()-1] !== want) begin n_fail++; $display("FAIL short_tx_en_len: got %0d want %0d", flen_q[flen_q.size()-1], want); end
    endtask

    task automatic test_underrun();
        bq_t p    = rand_payload(30);
        lq_t full = bytes_to_bits(wire_bytes(p));
        lq_t exp;
        int  c0 = cap_q.size(), fd0 = fd_cnt, u0 = ur_cnt, ub0 = urbad, r0 = rdy_cnt, e;
        int  want = 8 * PRE + 8 + 8 * 20;
        for (int i = 0; i < want; i++) exp.push_back(full[i]);
        drive(p, last_flags(30), 20, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks += 7;
        if (ur_cnt - u0 !== 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d want 1", ur_cnt - u0); end
        if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL underrun_frame_done: got %0d want 0", fd_cnt - fd0); end
        if (urbad !== ub0) begin n_fail++; $display("FAIL underrun_tx_en_next: got %0d high cycles want 0", urbad - ub0); end
        if (flen_q[flen_q.size()-1] !== want) begin n_fail++; $display("FAIL underrun_tx_en_len: got %0d want %0d", flen_q[flen_q.size()-1], want); end
        if (e !== 0) begin n_fail++; $display("FAIL underrun_stream: %0d bit errors, want 0", e); end
        if (rdy_cnt - r0 !== 20) begin n_fail++; $display("FAIL underrun_ready: got %0d want 20", rdy_cnt - r0); end
        if (tail_q[tail_q.size()-1] !== IPG) begin n_fail++; $display("FAIL underrun_ipg: got %0d want %0d", tail_q[tail_q.size()-1], IPG); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t p = rand_payload(40);
        bq_t q = rand_payload(25);
        lq_t exp = bytes_to_bits(wire_bytes(q));
        int  fd0 = fd_cnt, u0 = ur_cnt, c0, e;
        drive(p, last_flags(40), -1, 10);
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if ({tx_en, tx_bit, bus.s_ready, busy, frame_done, underrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: en=%b bit=%b rdy=%b busy=%b fd=%b ur=%b want all 0",
                     tx_en, tx_bit, bus.s_ready, busy, frame_done, underrun);
        end
        if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL midreset_frame_done: got %0d want 0", fd_cnt - fd0); end
        if (ur_cnt - u0 !== 0) begin n_fail++; $display("FAIL midreset_underrun: got %0d want 0", ur_cnt - u0); end
        c0 = cap_q.size();
        drive(q, last_flags(25), -1, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL midreset_next_frame: %0d bit errors, want 0", e); end
    endtask

    task automatic test_back_to_back();
        bq_t a = rand_payload(20);
        bq_t b = rand_payload(64);
        bq_t d;
        lq_t l;
        lq_t la = last_flags(20);
        lq_t lb = last_flags(64);
        lq_t exp = bytes_to_bits(wire_bytes(a));
        lq_t eb  = bytes_to_bits(wire_bytes(b));
        int  c0 = cap_q.size(), g0 = gap_q.size(), fd0 = fd_cnt, e;
        foreach (eb[i]) exp.push_back(eb[i]);
        foreach (a[i]) begin d.push_back(a[i]); l.push_back(la[i]); end
        foreach (b[i]) begin d.push_back(b[i]); l.push_back(lb[i]); end
        drive(d, l, -1, -1);
        wait_idle();
        e = stream_errs(c0, exp);
        n_checks += 3;
        if (e !== 0) begin n_fail++; $display("FAIL b2b_stream: %0d bit errors, want 0", e); end
        if (fd_cnt - fd0 !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt - fd0); end
        if (gap_q.size() <= g0 || gap_q[gap_q.size()-1] !== IPG) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d want %0d", (gap_q.size() > g0) ? gap_q[gap_q.size()-1] : -1, IPG);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        rst         = 1'b1;
        test_reset();
        test_check_value();
        test_random_frames();
        test_sixty_bytes();
        test_short_payload();
        test_underrun();
        test_reset_mid_frame();
        test_back_to_back();
        n_checks++;
        if (zbad !== 0) begin n_fail++; $display("FAIL tx_bit_idle: %0d cycles with tx_bit=1 while tx_en=0, want 0", zbad); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameter IPG_BITS, default 96, interframe gap length in bit times (clk cycles).
REQ-002 Parameter PREAMBLE_BYTES, default 7, number of 0x55 preamble bytes before the SFD.
REQ-003 clk  input  1  bit-rate clock, 10 MHz, one serial bit per cycle.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 s_data  input  8  payload byte (destination MAC first).
REQ-006 s_valid  input  1  s_data/s_last valid.
REQ-007 s_last  input  1  current byte is the last payload byte.
REQ-008 s_ready  output  1  byte taken this cycle when s_valid is also high.
REQ-009 tx_bit  output  1  NRZ serial bit to the Manchester encoder.
REQ-010 tx_en  output  1  frame active; tx_bit meaningful only while high.
REQ-011 busy  output  1  high from frame start to the end of the IPG.
REQ-012 frame_done  output  1  one-cycle pulse on the last FCS bit.
REQ-013 underrun  output  1  one-cycle pulse when a frame is aborted for missing data.

Function
REQ-014 States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG; 3-bit bit counter, 11-bit saturating byte counter.
REQ-015 IDLE with s_valid=1 -> PREAMBLE next cycle, without consuming the byte; tx_en rises in that cycle (latency 1).
REQ-016 All bytes are sent LSB first; preamble = PREAMBLE_BYTES x 0x55 (bits 1,0,1,0...), SFD = 0xD5 (bits 1,0,1,0,1,0,1,1).
REQ-017 s_ready is high only in the cycle carrying bit 7 of SFD or of a DATA byte whose s_last was 0; the byte is loaded into the shift register on that edge.
REQ-018 In DATA, the byte with s_last=1 ends payload; next state PAD if byte count < 60 (see Configuration), else FCS.
REQ-019 s_valid=0 in a cycle where s_ready=1 -> underrun pulse, tx_en low next cycle, no FCS, go to IPG.
REQ-020 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per bit over DATA and PAD bits only; FCS = bitwise complement, sent LSB first (32 bits).
REQ-021 PAD sends 0x00 bytes until the byte count reaches 60.
REQ-022 After FCS: tx_en low, IPG for IPG_BITS cycles (busy=1, s_ready=0), then IDLE.
REQ-023 tx_en high time = 8*PREAMBLE_BYTES + 8 + 8*(payload+pad) + 32 cycles, contiguous.
REQ-024 Byte counter saturates at 2047; no length limit enforced.
REQ-025 tx_bit = 0 whenever tx_en = 0.

Reset
REQ-026 rst=1 on any clk edge: state IDLE, tx_en=0, tx_bit=0, s_ready=0, busy=0, frame_done=0, underrun=0, CRC=0xFFFFFFFF, counters 0.
REQ-027 Reset mid-frame takes effect on that edge; frame is dropped, no FCS, no IPG, no pulses.
REQ-028 First frame may start the cycle after rst deasserts.

Configuration
REQ-029 Macro ETH_TX_PAD_EN defined: PAD state present, payload < 60 bytes zero-padded to 60 before FCS.
REQ-030 ETH_TX_PAD_EN undefined: no PAD state; FCS follows the last payload byte regardless of length.

Verification
REQ-031 PAD off, payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB; tx_en high 64+72+32=168 cycles; frame_done once.
REQ-032 PAD on, 60-byte payload of 0x00..0x3B -> tx_en high 576 cycles, 60 s_ready pulses, then busy high 96 more cycles with tx_en low.
REQ-033 PAD on, 14-byte payload -> 46 zero bytes appended, tx_en high 576 cycles, FCS matches CRC over 60 bytes.
REQ-034 s_valid dropped at byte 20 -> underrun pulse, tx_en low next cycle, no frame_done, IPG of 96 cycles then IDLE.
REQ-035 rst pulsed during DATA byte 10 -> all outputs at reset values next cycle; new frame starts cleanly after rst falls.
REQ-036 s_valid held high continuously for two back-to-back frames -> exactly IPG_BITS cycles with tx_en low between them.
